sdram_scheduler: RTL and testbench
==================================

# sdram_scheduler

Top-level sequencer for the SDRAM port: sequences the power-up init engine, periodic auto-refresh, and the single-burst write and read engines that share the DRAM pins through their `ienb` tri-state enables. It guarantees that at most one engine drives the bus at any time. It arbitrates client write/read requests fairly, with refresh always taking priority, and has a per-operation watchdog. It sits between the CPU memory interface and the init/refresh/read/write SDRAM engines.

## Interface
Parameters:
- `REFRESH_CYCLES`, 390: `iclk` cycles between refresh ticks (7.8 us at 50 MHz).
- `TIMEOUT_CYCLES`, 255: maximum cycles an engine may hold the bus before abort.

Ports:
- `iclk`  in  1  clock, all logic on rising edge.
- `ctr_reset`  in  1  reset, asynchronous, active-high.
- `iwr_req`  in  1  client write request, level, held until `owr_ack`.
- `ird_req`  in  1  client read request, level, held until `ord_ack`.
- `owr_ack` / `ord_ack`  out  1  one-cycle pulse: client op complete.
- `oinit_req`, `oref_req`, `owe_req`, `ore_req`  out  1  one-cycle start pulse to the init/refresh/write/read engine.
- `oinit_enb`, `oref_enb`, `owe_enb`, `ore_enb`  out  1  bus enable to that engine, held for the whole operation.
- `iinit_fin`, `iref_fin`, `iwe_fin`, `ire_fin`  in  1  done pulse from that engine.
- `obusy`  out  1  high in any state except IDLE.
- `oerr`  out  1  one-cycle pulse on watchdog abort.
- `oref_overrun`  out  1  one-cycle pulse: refresh tick arrived while a refresh was still pending.

## Operation
- States: INIT, IDLE, REFRESH, WRITE, READ (registered, one-hot or binary).
- INIT: entered on reset. `oinit_enb`=1. `oinit_req` pulses on the first cycle after reset release. Stays in INIT until `iinit_fin`, then goes to IDLE. The watchdog is not applied in INIT.
- Refresh timer:
  - Counts 0..REFRESH_CYCLES-1 and wraps. It runs only outside INIT and holds 0 during INIT.
  - On wrap it sets `ref_pending`. If `ref_pending` is already set, `oref_overrun` pulses and the flag stays 1.
- Arbitration in IDLE, evaluated each cycle in this priority order:
  1. `ref_pending` -> REFRESH.
  2. Both client requests high -> the one not served last (`last_wr` flag; write wins after reset).
  3. Only one request high -> that one.
- Grant entry (first cycle in REFRESH/WRITE/READ): the matching `o*_req` pulses high for exactly that cycle. The matching `o*_enb` goes high on the same cycle and stays high until the state exits.
- REFRESH exit: on `iref_fin`, clear `ref_pending` and go to IDLE. A tick coinciding with `iref_fin` re-sets `ref_pending`, so set wins over clear.
- WRITE exit: on `iwe_fin`, pulse `owr_ack`, set `last_wr`=1, go to IDLE.
- READ exit: on `ire_fin`, pulse `ord_ack`, set `last_wr`=0, go to IDLE.
- Watchdog:
  - 8+ bit counter, cleared on grant entry, increments each cycle in REFRESH/WRITE/READ.
  - On reaching TIMEOUT_CYCLES: pulse `oerr` and return to IDLE. No `*_ack` is issued; the client request remains and is re-arbitrated. A refresh abort leaves `ref_pending` set.
- `*_fin` inputs not matching the current state are ignored.
- Enables are mutually exclusive at all times. At most one `o*_enb` is high; all are 0 in IDLE.

## Timing
- Reset values: `oinit_enb`=1. All other outputs are 0 except `obusy`=1. State = INIT, `ref_pending`=0, `last_wr`=0, timers 0.
- Reset asserted mid-operation: the state returns to INIT immediately (asynchronously). All grants drop the same instant; no ack is issued.
- IDLE -> grant: one cycle. A request sampled high in IDLE at edge N gives the grant state and `o*_req`/`o*_enb` high after edge N.
- fin -> IDLE: `*_fin` sampled at edge M. After edge M the state is IDLE, `*_enb`=0, and `*_ack` is high for that one cycle.
- The earliest re-grant is the edge after the ack cycle, giving a minimum of one IDLE cycle between operations for bus turnaround.
- Client must drop its request in the ack cycle. A request still high on the next edge is treated as a new operation.

## Test plan
- Reset, hold `iinit_fin`=0 for 20 cycles, then pulse it -> `oinit_enb`=1 throughout and `oinit_req` pulses once at cycle 1. After the fin edge: IDLE, `obusy`=0, all enables 0.
- Single write: `iwr_req`=1, `iwe_fin` 9 cycles after `owe_req` -> `owe_enb` high for exactly 10 cycles, `owr_ack` one pulse, then `obusy`=0.
- `iwr_req` and `ird_req` both high, fins after 5 cycles each, both requests re-raised -> grants follow the order W, R, W, R (alternating; write first after reset).
- REFRESH_CYCLES=50 with continuous read traffic -> a refresh is granted within one read operation after each tick, and `oref_overrun` never fires. Then block `iref_fin` for 60 cycles with TIMEOUT_CYCLES=200 -> `oref_overrun` pulses once.
- TIMEOUT_CYCLES=16, write granted with `iwe_fin` never asserted -> `oerr` pulses 16 cycles after grant, `owe_enb` drops, no `owr_ack`, and the write is re-granted one cycle later.
- Assert `ctr_reset` in the middle of a READ -> `ore_enb` falls without waiting for a clock, state is INIT, and no `ord_ack` is issued.

Source files
------------

// File: rtl/sdram_scheduler_if.sv
// Bundle of client, engine and status signals around the SDRAM port scheduler.
// The master modport is the scheduler side; the slave modport is the
// environment (CPU client plus init/refresh/write/read engines).
//
// Handshake semantics: iwr_req/ird_req are levels held by the client until the
// matching one-cycle ack; the client drops the level in the ack cycle. Each
// engine gets a one-cycle o*_req start pulse together with its o*_enb bus
// enable, and answers with a one-cycle i*_fin done pulse; o*_enb stays high
// until the scheduler leaves that state.
interface sdram_scheduler_if;
   logic       iwr_req;
   logic       ird_req;
   logic       owr_ack;
   logic       ord_ack;
   logic       oinit_req;
   logic       oref_req;
   logic       owe_req;
   logic       ore_req;
   logic       oinit_enb;
   logic       oref_enb;
   logic       owe_enb;
   logic       ore_enb;
   logic       iinit_fin;
   logic       iref_fin;
   logic       iwe_fin;
   logic       ire_fin;
   logic       obusy;
   logic       oerr;
   logic       oref_overrun;
   logic [2:0] ostate;

   modport master (
      input  iwr_req, ird_req, iinit_fin, iref_fin, iwe_fin, ire_fin,
      output owr_ack, ord_ack, oinit_req, oref_req, owe_req, ore_req,
      output oinit_enb, oref_enb, owe_enb, ore_enb,
      output obusy, oerr, oref_overrun, ostate
   );

   modport slave (
      output iwr_req, ird_req, iinit_fin, iref_fin, iwe_fin, ire_fin,
      input  owr_ack, ord_ack, oinit_req, oref_req, owe_req, ore_req,
      input  oinit_enb, oref_enb, owe_enb, ore_enb,
      input  obusy, oerr, oref_overrun, ostate
   );
endinterface

// File: rtl/sdram_scheduler.sv
// SDRAM port sequencer: power-up init, periodic refresh, and fair write/read
// arbitration. Exactly one engine owns the DRAM pins at a time through its
// enable; refresh always wins in IDLE, and a watchdog aborts stuck operations.
// ostate exposes the FSM state: 0 INIT, 1 IDLE, 2 REFRESH, 3 WRITE, 4 READ.
module sdram_scheduler #(
   parameter int REFRESH_CYCLES = 390,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic               iclk,
   input logic               ctr_reset,
   sdram_scheduler_if.master bus
);

   localparam int RC_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int WD_W  = (WD_RAW > 8) ? WD_RAW : 8;
   localparam logic [RC_W-1:0] REF_LAST = RC_W'(REFRESH_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_IDLE    = 3'd1,
      S_REFRESH = 3'd2,
      S_WRITE   = 3'd3,
      S_READ    = 3'd4
   } state_t;

   state_t          state;
   logic [RC_W-1:0] ref_cnt;
   logic [WD_W-1:0] wd_cnt;
   logic            ref_pending;
   logic            last_wr;
   logic            init_issued;
   logic            ref_tick;
   logic            wd_expire;

   // The timer is parked at 0 while in INIT, so the first tick lands a full
   // period after init completes.
   assign ref_tick  = (state != S_INIT) && (ref_cnt == REF_LAST);
   // Abort on the edge at which the count would reach the limit, so oerr is
   // visible exactly TIMEOUT_CYCLES cycles after the grant cycle.
   assign wd_expire = (wd_cnt == WD_LAST);
   assign bus.ostate = state;

   // Free-running refresh interval timer, held at zero during INIT.
   always_ff @(posedge iclk or posedge ctr_reset) begin
      if (ctr_reset) begin
         ref_cnt <= '0;
      end else if (state == S_INIT || ref_tick) begin
         ref_cnt <= '0;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   // Main FSM with registered start pulses, enables, acks and status.
   always_ff @(posedge iclk or posedge ctr_reset) begin
      if (ctr_reset) begin
         state            <= S_INIT;
         ref_pending      <= 1'b0;
         last_wr          <= 1'b0;
         init_issued      <= 1'b0;
         wd_cnt           <= '0;
         bus.oinit_req    <= 1'b0;
         bus.oref_req     <= 1'b0;
         bus.owe_req      <= 1'b0;
         bus.ore_req      <= 1'b0;
         bus.oinit_enb    <= 1'b1;
         bus.oref_enb     <= 1'b0;
         bus.owe_enb      <= 1'b0;
         bus.ore_enb      <= 1'b0;
         bus.owr_ack      <= 1'b0;
         bus.ord_ack      <= 1'b0;
         bus.obusy        <= 1'b1;
         bus.oerr         <= 1'b0;
         bus.oref_overrun <= 1'b0;
      end else begin
         bus.oinit_req    <= 1'b0;
         bus.oref_req     <= 1'b0;
         bus.owe_req      <= 1'b0;
         bus.ore_req      <= 1'b0;
         bus.owr_ack      <= 1'b0;
         bus.ord_ack      <= 1'b0;
         bus.oerr         <= 1'b0;
         bus.oref_overrun <= ref_tick && ref_pending;
         if (ref_tick) begin
            ref_pending <= 1'b1;
         end

         case (state)
            S_INIT: begin
               if (bus.iinit_fin) begin
                  state         <= S_IDLE;
                  bus.oinit_enb <= 1'b0;
                  bus.obusy     <= 1'b0;
               end else if (!init_issued) begin
                  bus.oinit_req <= 1'b1;
                  init_issued   <= 1'b1;
               end
            end

            S_IDLE: begin
               wd_cnt <= '0;
               if (ref_pending) begin
                  state        <= S_REFRESH;
                  bus.oref_req <= 1'b1;
                  bus.oref_enb <= 1'b1;
                  bus.obusy    <= 1'b1;
               end else if (bus.iwr_req && (!bus.ird_req || !last_wr)) begin
                  state       <= S_WRITE;
                  bus.owe_req <= 1'b1;
                  bus.owe_enb <= 1'b1;
                  bus.obusy   <= 1'b1;
               end else if (bus.ird_req) begin
                  state       <= S_READ;
                  bus.ore_req <= 1'b1;
                  bus.ore_enb <= 1'b1;
                  bus.obusy   <= 1'b1;
               end
            end

            S_REFRESH: begin
               if (bus.iref_fin || wd_expire) begin
                  // A tick on the same edge keeps the flag set.
                  if (bus.iref_fin && !ref_tick) begin
                     ref_pending <= 1'b0;
                  end
                  bus.oerr     <= !bus.iref_fin;
                  state        <= S_IDLE;
                  bus.oref_enb <= 1'b0;
                  bus.obusy    <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end

            S_WRITE: begin
               if (bus.iwe_fin) begin
                  bus.owr_ack <= 1'b1;
                  last_wr     <= 1'b1;
                  state       <= S_IDLE;
                  bus.owe_enb <= 1'b0;
                  bus.obusy   <= 1'b0;
               end else if (wd_expire) begin
                  bus.oerr    <= 1'b1;
                  state       <= S_IDLE;
                  bus.owe_enb <= 1'b0;
                  bus.obusy   <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end

            S_READ: begin
               if (bus.ire_fin) begin
                  bus.ord_ack <= 1'b1;
                  last_wr     <= 1'b0;
                  state       <= S_IDLE;
                  bus.ore_enb <= 1'b0;
                  bus.obusy   <= 1'b0;
               end else if (wd_expire) begin
                  bus.oerr    <= 1'b1;
                  state       <= S_IDLE;
                  bus.ore_enb <= 1'b0;
                  bus.obusy   <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end

            default: begin
               state         <= S_IDLE;
               bus.oinit_enb <= 1'b0;
               bus.oref_enb  <= 1'b0;
               bus.owe_enb   <= 1'b0;
               bus.ore_enb   <= 1'b0;
               bus.obusy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_scheduler.sv
// Bench for sdram_scheduler. Two instances run side by side: dut_m (refresh
// effectively disabled, short watchdog) for arbitration/watchdog/reset work,
// and dut_r (50-cycle refresh) under continuous read traffic for refresh
// latency and overrun behaviour. A single process drives every input through
// step(), which also runs the engine/client models and the grant scoreboards.
module tb_sdram_scheduler;

   localparam int ST_INIT = 0;
   localparam int ST_IDLE = 1;
   localparam int R_PERIOD = 50;
   localparam int R_WINDOW = 10;

   logic iclk = 1'b0;
   logic ctr_reset;

   always #5 iclk = ~iclk;

   sdram_scheduler_if m_if ();
   sdram_scheduler_if r_if ();

   sdram_scheduler #(.REFRESH_CYCLES(5000), .TIMEOUT_CYCLES(16)) dut_m (
      .iclk(iclk), .ctr_reset(ctr_reset), .bus(m_if.master)
   );

   sdram_scheduler #(.REFRESH_CYCLES(50), .TIMEOUT_CYCLES(200)) dut_r (
      .iclk(iclk), .ctr_reset(ctr_reset), .bus(r_if.master)
   );

   typedef struct {
      int wr_left; int rd_left; int cnt; int kind;
      int lat_ref; int lat_wr; int lat_rd; int ref_done;
   } eng_t;

   typedef struct {
      int wr_n; int rd_n; int lat_wr; int lat_rd;
      logic [7:0] grants; int n_g; int enb_cyc;
   } vec_t;

   int total = 0;
   int bad = 0;
   eng_t m_e;
   eng_t r_e;
   logic [1:0]  m_exp_q[$];
   logic [31:0] r_exp_q[$];
   int   m_enb_cyc;
   int   m_ack_cnt;
   logic m_gnt;
   logic r_on = 1'b0;
   int   r_k;
   int   r_ovr_cnt = 0;
   vec_t vec[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Engine and client behaviour: fin a fixed latency after the start pulse,
   // drop the client request in its ack cycle and re-raise while work remains.
   function automatic void model(input logic ref_req, we_req, re_req, wr_ack, rd_ack, err,
                                 inout eng_t e, output logic wr_req, rd_req,
                                 output logic ref_fin, we_fin, re_fin);
      int lat;
      ref_fin = 1'b0; we_fin = 1'b0; re_fin = 1'b0;
      if (ref_req || we_req || re_req) begin
         e.cnt = 0;
         e.kind = ref_req ? 1 : (we_req ? 2 : 3);
      end else if (err) begin
         e.kind = 0;
      end else if (e.kind != 0) begin
         e.cnt++;
      end
      lat = (e.kind == 1) ? e.lat_ref : ((e.kind == 2) ? e.lat_wr : e.lat_rd);
      if (e.kind != 0 && e.cnt == lat) begin
         ref_fin = (e.kind == 1);
         we_fin  = (e.kind == 2);
         re_fin  = (e.kind == 3);
         if (e.kind == 1) e.ref_done++;
         e.kind = 0;
      end
      if (wr_ack) begin e.wr_left--; wr_req = 1'b0; end
      else wr_req = (e.wr_left > 0);
      if (rd_ack) begin e.rd_left--; rd_req = 1'b0; end
      else rd_req = (e.rd_left > 0);
   endfunction

   task automatic step();
      logic [1:0] code;
      logic wq, rq, rf, wf, ef;
      logic tick, exp_ovr;
      @(negedge iclk);
      m_gnt = 1'b0;
      check("m_excl", 32'($countones({m_if.oinit_enb, m_if.oref_enb, m_if.owe_enb, m_if.ore_enb}) <= 1), 1);
      check("r_excl", 32'($countones({r_if.oinit_enb, r_if.oref_enb, r_if.owe_enb, r_if.ore_enb}) <= 1), 1);
      if (m_if.owr_ack || m_if.ord_ack) begin
         m_ack_cnt++;
         check("m_ack_idle", {m_if.obusy, m_if.oinit_enb, m_if.oref_enb, m_if.owe_enb, m_if.ore_enb}, 0);
      end
      m_enb_cyc += int'(m_if.owe_enb) + int'(m_if.ore_enb);
      if (m_if.oref_req || m_if.owe_req || m_if.ore_req) begin
         m_gnt = 1'b1;
         code = m_if.oref_req ? 2'd1 : (m_if.owe_req ? 2'd2 : 2'd3);
         check("m_grant_enb", {m_if.oref_enb, m_if.owe_enb, m_if.ore_enb},
               (code == 2'd1) ? 3'b100 : ((code == 2'd2) ? 3'b010 : 3'b001));
         if (m_exp_q.size() == 0) check("m_grant_unexpected", code, 0);
         else check("m_grant", code, m_exp_q.pop_front());
      end
      // Refresh-side prediction for dut_r: ticks land every R_PERIOD cycles
      // after it leaves INIT; each unmerged tick must be granted promptly.
      if (r_on) begin
         r_k++;
         tick = ((r_k % R_PERIOD) == 0);
         exp_ovr = tick && (r_e.kind == 1 || r_exp_q.size() > 0);
         check("r_overrun", r_if.oref_overrun, exp_ovr);
         if (tick && !exp_ovr) r_exp_q.push_back(r_k);
         if (r_if.oref_req) begin
            if (r_exp_q.size() == 0) check("r_ref_unexpected", r_k, 0);
            else check("r_ref_latency", 32'((r_k - int'(r_exp_q.pop_front())) <= R_WINDOW), 1);
         end
         if (r_exp_q.size() > 0 && (r_k - int'(r_exp_q[0])) > R_WINDOW) begin
            check("r_ref_timeout", r_k - int'(r_exp_q[0]), R_WINDOW);
            void'(r_exp_q.pop_front());
         end
      end
      r_ovr_cnt += int'(r_if.oref_overrun);

      model(m_if.oref_req, m_if.owe_req, m_if.ore_req, m_if.owr_ack, m_if.ord_ack, m_if.oerr,
            m_e, wq, rq, rf, wf, ef);
      m_if.iwr_req = wq; m_if.ird_req = rq;
      m_if.iref_fin = rf; m_if.iwe_fin = wf; m_if.ire_fin = ef;
      model(r_if.oref_req, r_if.owe_req, r_if.ore_req, r_if.owr_ack, r_if.ord_ack, r_if.oerr,
            r_e, wq, rq, rf, wf, ef);
      r_if.iwr_req = wq; r_if.ird_req = rq;
      r_if.iref_fin = rf; r_if.iwe_fin = wf; r_if.ire_fin = ef;
   endtask

   initial begin
      int n;
      int d0;
      vec_t v;

      // {wr count, rd count, write lat, read lat, grant codes (2=W 3=R, first in LSBs), n grants, enable cycles}
      vec[0] = '{2, 2, 5, 5, 8'hEE, 4, 24};
      vec[1] = '{1, 0, 9, 9, 8'h02, 1, 10};
      vec[2] = '{0, 1, 3, 3, 8'h03, 1, 4};
      vec[3] = '{1, 1, 2, 2, 8'h0E, 2, 6};
      vec[4] = '{0, 3, 1, 1, 8'h3F, 3, 6};
      vec[5] = '{3, 1, 4, 4, 8'hAE, 4, 20};
      vec[6] = '{1, 2, 3, 6, 8'h3B, 3, 18};

      m_e = '{0, 0, 0, 0, 3, 5, 5, 0};
      r_e = '{0, 0, 0, 0, 3, 5, 5, 0};
      m_if.iwr_req = 0; m_if.ird_req = 0; m_if.iinit_fin = 0;
      m_if.iref_fin = 0; m_if.iwe_fin = 0; m_if.ire_fin = 0;
      r_if.iwr_req = 0; r_if.ird_req = 0; r_if.iinit_fin = 0;
      r_if.iref_fin = 0; r_if.iwe_fin = 0; r_if.ire_fin = 0;

      // Clock/reset: asynchronous reset values before any clock edge.
      ctr_reset = 1'b1;
      #2;
      check("rst_init_enb", m_if.oinit_enb, 1);
      check("rst_busy", m_if.obusy, 1);
      check("rst_state", m_if.ostate, ST_INIT);
      check("rst_pulses", {m_if.oinit_req, m_if.oref_req, m_if.owe_req, m_if.ore_req,
                           m_if.owr_ack, m_if.ord_ack, m_if.oerr, m_if.oref_overrun}, 0);
      check("rst_enbs", {m_if.oref_enb, m_if.owe_enb, m_if.ore_enb}, 0);
      @(negedge iclk);
      ctr_reset = 1'b0;

      // Init sequence: enable held, one start pulse in cycle 1, then fin.
      for (int c = 1; c <= 20; c++) begin
         step();
         check($sformatf("init_enb_c%0d", c), m_if.oinit_enb, 1);
         check($sformatf("init_req_c%0d", c), m_if.oinit_req, (c == 1));
      end
      m_if.iinit_fin = 1'b1;
      r_if.iinit_fin = 1'b1;
      step();
      m_if.iinit_fin = 1'b0;
      r_if.iinit_fin = 1'b0;
      check("init_done_state", m_if.ostate, ST_IDLE);
      check("init_done_busy", m_if.obusy, 0);
      check("init_done_enbs", {m_if.oinit_enb, m_if.oref_enb, m_if.owe_enb, m_if.ore_enb}, 0);
      check("r_init_done_state", r_if.ostate, ST_IDLE);
      r_on = 1'b1;
      r_k = 0;
      r_e.rd_left = 1000000;

      // Table-driven arbitration vectors on dut_m.
      for (int i = 0; i < 7; i++) begin
         v = vec[i];
         m_e.lat_wr = v.lat_wr;
         m_e.lat_rd = v.lat_rd;
         for (int g = 0; g < v.n_g; g++) m_exp_q.push_back(v.grants[2*g +: 2]);
         m_enb_cyc = 0;
         m_ack_cnt = 0;
         m_e.wr_left = v.wr_n;
         m_e.rd_left = v.rd_n;
         n = 0;
         while ((m_e.wr_left > 0 || m_e.rd_left > 0) && n < 300) begin
            step();
            n++;
         end
         check($sformatf("vec%0d_remaining", i), m_e.wr_left + m_e.rd_left, 0);
         step();
         check($sformatf("vec%0d_idle", i), {m_if.obusy, m_if.owe_enb, m_if.ore_enb}, 0);
         check($sformatf("vec%0d_enb_cycles", i), m_enb_cyc, v.enb_cyc);
         check($sformatf("vec%0d_acks", i), m_ack_cnt, v.wr_n + v.rd_n);
         check($sformatf("vec%0d_grants_left", i), m_exp_q.size(), 0);
         m_exp_q.delete();
      end

      // Long refresh on dut_r: a tick arrives while the refresh is pending.
      r_e.lat_ref = 60;
      d0 = r_e.ref_done;
      n = 0;
      while (r_e.ref_done == d0 && n < 300) begin
         step();
         n++;
      end
      r_e.lat_ref = 3;
      check("r_long_ref_done", r_e.ref_done - d0, 1);
      check("r_overrun_once", r_ovr_cnt, 1);

      // Watchdog on dut_m: write engine never finishes.
      m_e.lat_wr = 1000;
      m_ack_cnt = 0;
      m_exp_q.push_back(2'd2);
      m_e.wr_left = 1;
      n = 0;
      do begin step(); n++; end while (!m_gnt && n < 10);
      check("wd_first_grant", m_gnt, 1);
      n = 0;
      do begin step(); n++; end while (!m_if.oerr && n < 40);
      check("wd_err_cycles", n, 16);
      check("wd_enb_dropped", m_if.owe_enb, 0);
      check("wd_no_ack", m_if.owr_ack, 0);
      check("wd_state_idle", m_if.ostate, ST_IDLE);
      m_exp_q.push_back(2'd2);
      m_e.lat_wr = 3;
      step();
      check("wd_regrant", m_if.owe_req, 1);
      n = 0;
      while (m_e.wr_left > 0 && n < 40) begin step(); n++; end
      check("wd_write_completed", m_e.wr_left, 0);
      check("wd_ack_count", m_ack_cnt, 1);

      // Let dut_r run a few more normal refresh periods.
      for (int c = 0; c < 120; c++) step();
      check("r_overrun_total", r_ovr_cnt, 1);
      check("r_refresh_count", 32'(r_e.ref_done >= 5), 1);

      // Reset in the middle of a READ on dut_m.
      r_on = 1'b0;
      m_e.lat_rd = 1000;
      m_ack_cnt = 0;
      m_exp_q.push_back(2'd3);
      m_e.rd_left = 1;
      n = 0;
      do begin step(); n++; end while (!m_gnt && n < 10);
      check("rst_read_grant", m_gnt, 1);
      for (int c = 0; c < 5; c++) step();
      check("rst_read_enb_before", m_if.ore_enb, 1);
      #2;
      ctr_reset = 1'b1;
      #1;
      check("rst_async_re_enb", m_if.ore_enb, 0);
      check("rst_async_state", m_if.ostate, ST_INIT);
      check("rst_async_init_enb", m_if.oinit_enb, 1);
      for (int c = 0; c < 3; c++) step();
      check("rst_no_read_ack", m_ack_cnt, 0);
      check("rst_hold_re_enb", m_if.ore_enb, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
